// File: rtl/polygon_pkg.sv
// Shared definitions for the polygon loader: default geometry parameters,
// vertex-count width helper and the loader state encoding.
package polygon_pkg;

  localparam int unsigned WORLD_BITS       = 32;
  localparam int unsigned MAX_NUM_VERTICES = 32;

  // Width needed to hold a count from 0 up to and including n.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned CNT_BITS = cnt_bits(MAX_NUM_VERTICES);

  typedef enum logic [0:0] {
    StLoad,
    StFull
  } state_e;

endpackage

// File: rtl/polygon_loader_if.sv
// Vertex stream handshake into the polygon loader.
//   vx_in, vy_in : world coordinates of the offered vertex
//   v_valid_in   : a vertex is offered this cycle
//   v_last_in    : offered vertex closes its polygon
//   v_ready_out  : loader accepts the offered vertex this cycle
// master drives the vertices, slave (the loader) drives ready.
interface polygon_loader_if #(
  parameter int unsigned WORLD_BITS = polygon_pkg::WORLD_BITS
) ();

  logic signed [WORLD_BITS-1:0] vx_in;
  logic signed [WORLD_BITS-1:0] vy_in;
  logic                         v_valid_in;
  logic                         v_last_in;
  logic                         v_ready_out;

  modport master (
    output vx_in,
    output vy_in,
    output v_valid_in,
    output v_last_in,
    input  v_ready_out
  );

  modport slave (
    input  vx_in,
    input  vy_in,
    input  v_valid_in,
    input  v_last_in,
    output v_ready_out
  );

endinterface

// File: rtl/polygon_loader.sv
// Double-buffered polygon vertex loader.
// Vertices arrive on vtx_if, are made camera-relative and written into a
// shadow bank. Once a polygon is closed (v_last_in) the loader stalls until a
// frame-boundary swap_in copies the shadow bank to the active bank, which is
// what the outputs show. Every output is a flop, so nothing is combinational
// from inputs to outputs.
// Ports:
//   clk_in, rst_n_in        : clock, asynchronous active-low reset
//   vtx_if (slave)          : vertex stream handshake
//   cam_x_in, cam_y_in      : camera offset subtracted from each vertex
//   swap_in                 : frame-boundary swap request
//   poly_xs_out/poly_ys_out : active bank coordinate arrays
//   num_points_out          : active vertex count
//   poly_valid_out          : active polygon has at least 3 vertices
//   overflow_out            : sticky, some polygon exceeded capacity
module polygon_loader
  import polygon_pkg::*;
#(
  parameter int unsigned WORLD_BITS       = polygon_pkg::WORLD_BITS,
  parameter int unsigned MAX_NUM_VERTICES = polygon_pkg::MAX_NUM_VERTICES,
  localparam int unsigned CntW            = cnt_bits(MAX_NUM_VERTICES)
) (
  input  logic                                         clk_in,
  input  logic                                         rst_n_in,
  polygon_loader_if.slave                              vtx_if,
  input  logic signed [WORLD_BITS-1:0]                 cam_x_in,
  input  logic signed [WORLD_BITS-1:0]                 cam_y_in,
  input  logic                                         swap_in,
  output logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0]  poly_xs_out,
  output logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0]  poly_ys_out,
  output logic [CntW-1:0]                              num_points_out,
  output logic                                         poly_valid_out,
  output logic                                         overflow_out
);

  localparam int unsigned IdxW   = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_NUM_VERTICES);
  localparam logic [CntW-1:0] MinPolyCnt = CntW'(3);

  state_e                                       state_q, state_d;
  logic                                         ready_q, ready_d;
  logic [CntW-1:0]                              count_q, count_d;
  logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0]  sh_x_q, sh_x_d;
  logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0]  sh_y_q, sh_y_d;
  logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0]  act_x_q, act_x_d;
  logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0]  act_y_q, act_y_d;
  logic [CntW-1:0]                              num_q, num_d;
  logic                                         pvalid_q, pvalid_d;
  logic                                         ovf_q, ovf_d;

  logic            accept;
  logic [IdxW-1:0] wr_idx;

  // ready_q is zero in FULL, so accept can only happen in LOAD.
  assign accept = vtx_if.v_valid_in && ready_q;
  assign wr_idx = count_q[IdxW-1:0];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sh_x_d   = sh_x_q;
    sh_y_d   = sh_y_q;
    act_x_d  = act_x_q;
    act_y_d  = act_y_q;
    num_d    = num_q;
    pvalid_d = pvalid_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StLoad: begin
        // swap_in is deliberately ignored here, even alongside the last vertex.
        if (accept) begin
          if (count_q < MaxCnt) begin
            sh_x_d[wr_idx] = vtx_if.vx_in - cam_x_in;
            sh_y_d[wr_idx] = vtx_if.vy_in - cam_y_in;
            count_d        = count_q + 1'b1;
          end else begin
            // Bank full: drop the vertex but keep consuming until v_last_in.
            ovf_d = 1'b1;
          end
          if (vtx_if.v_last_in) begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        if (swap_in) begin
          act_x_d  = sh_x_q;
          act_y_d  = sh_y_q;
          num_d    = count_q;
          pvalid_d = (count_q >= MinPolyCnt);
          count_d  = '0;
          state_d  = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase

    ready_d = (state_d == StLoad);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StLoad;
      ready_q  <= 1'b0;
      count_q  <= '0;
      sh_x_q   <= '0;
      sh_y_q   <= '0;
      act_x_q  <= '0;
      act_y_q  <= '0;
      num_q    <= '0;
      pvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      count_q  <= count_d;
      sh_x_q   <= sh_x_d;
      sh_y_q   <= sh_y_d;
      act_x_q  <= act_x_d;
      act_y_q  <= act_y_d;
      num_q    <= num_d;
      pvalid_q <= pvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign vtx_if.v_ready_out = ready_q;
  assign poly_xs_out        = act_x_q;
  assign poly_ys_out        = act_y_q;
  assign num_points_out     = num_q;
  assign poly_valid_out     = pvalid_q;
  assign overflow_out       = ovf_q;

endmodule

// File: tb/tb_polygon_loader.sv
// Self-checking bench for polygon_loader. A queue-based model tracks the
// polygon being loaded and the polygon currently on the active outputs.
module tb_polygon_loader;
  import polygon_pkg::*;

  localparam int unsigned WB   = polygon_pkg::WORLD_BITS;
  localparam int unsigned MAXV = polygon_pkg::MAX_NUM_VERTICES;
  localparam int unsigned CW   = polygon_pkg::CNT_BITS;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic signed [WB-1:0]          cam_x, cam_y;
  logic                          swap;
  logic [MAXV-1:0][WB-1:0]       xs, ys;
  logic [CW-1:0]                 np;
  logic                          pv, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [WB-1:0] sh_xq[$], sh_yq[$], act_xq[$], act_yq[$];
  bit            m_full, m_ovf;

  polygon_loader_if #(.WORLD_BITS(WB)) vif ();

  polygon_loader dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .vtx_if         (vif),
    .cam_x_in       (cam_x),
    .cam_y_in       (cam_y),
    .swap_in        (swap),
    .poly_xs_out    (xs),
    .poly_ys_out    (ys),
    .num_points_out (np),
    .poly_valid_out (pv),
    .overflow_out   (ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    sh_xq.delete(); sh_yq.delete();
    act_xq.delete(); act_yq.delete();
    m_full = 0; m_ovf = 0;
  endtask

  // Polygon-level rules: a loading polygon absorbs vertices until closed,
  // keeps only the first MAXV, and a swap publishes a closed polygon.
  task automatic model_edge(input logic v, input logic [WB-1:0] x, input logic [WB-1:0] y,
                            input logic last, input logic sw);
    if (v && !m_full) begin
      if (sh_xq.size() < MAXV) begin
        sh_xq.push_back(x - cam_x);
        sh_yq.push_back(y - cam_y);
      end else begin
        m_ovf = 1;
      end
      if (last) m_full = 1;
    end else if (sw && m_full) begin
      act_xq = sh_xq;
      act_yq = sh_yq;
      sh_xq.delete(); sh_yq.delete();
      m_full = 0;
    end
  endtask

  task automatic cycle(input logic v, input logic [WB-1:0] x, input logic [WB-1:0] y,
                       input logic last, input logic sw);
    vif.v_valid_in = v;
    vif.vx_in      = x;
    vif.vy_in      = y;
    vif.v_last_in  = last;
    swap           = sw;
    model_edge(v, x, y, last, sw);
    @(posedge clk);
    #1;
    vif.v_valid_in = 1'b0;
    vif.v_last_in  = 1'b0;
    swap           = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vif.v_valid_in = 1'b0; vif.v_last_in = 1'b0; vif.vx_in = '0; vif.vy_in = '0;
    cam_x = '0; cam_y = '0; swap = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (np !== '0 || pv !== 1'b0 || ovf !== 1'b0 || vif.v_ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: np=%0d pv=%b ovf=%b rdy=%b, want all 0", np, pv, ovf,
               vif.v_ready_out);
    end
    n_tests++;
    if (xs !== '0 || ys !== '0) begin
      n_fail++;
      $display("FAIL reset_arrays: arrays nonzero, want 0");
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (vif.v_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", vif.v_ready_out);
    end
  endtask

  task automatic test_square();
    logic [WB-1:0] ex[4];
    logic [WB-1:0] ey[4];
    ex = '{0, 10, 10, 0};
    ey = '{0, 0, 10, 10};
    cam_x = 0; cam_y = 0;
    for (int i = 0; i < 4; i++) cycle(1'b1, ex[i], ey[i], i == 3, 1'b0);
    n_tests++;
    if (vif.v_ready_out !== 1'b0 || np !== '0) begin
      n_fail++;
      $display("FAIL square_pre_swap: rdy=%b np=%0d, want rdy 0 np 0", vif.v_ready_out, np);
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    n_tests++;
    if (np !== CW'(4) || pv !== 1'b1 || vif.v_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL square_swap: np=%0d pv=%b rdy=%b, want 4 1 1", np, pv, vif.v_ready_out);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (xs[i] !== ex[i] || ys[i] !== ey[i]) begin
        n_fail++;
        $display("FAIL square_entry%0d: got (%0d,%0d) want (%0d,%0d)", i, $signed(xs[i]),
                 $signed(ys[i]), $signed(ex[i]), $signed(ey[i]));
      end
    end
  endtask

  task automatic test_cam_offset();
    cam_x = 5; cam_y = -3;
    cycle(1'b1, 7, 7, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    n_tests++;
    if (np !== CW'(1) || pv !== 1'b0 || xs[0] !== WB'(2) || ys[0] !== WB'(10)) begin
      n_fail++;
      $display("FAIL cam_offset: np=%0d pv=%b v=(%0d,%0d), want 1 0 (2,10)", np, pv,
               $signed(xs[0]), $signed(ys[0]));
    end
  endtask

  task automatic test_short();
    cam_x = 0; cam_y = 0;
    cycle(1'b1, 1, 2, 1'b0, 1'b0);
    cycle(1'b1, 3, 4, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    n_tests++;
    if (np !== CW'(2) || pv !== 1'b0 || xs[0] !== WB'(1) || ys[1] !== WB'(4)) begin
      n_fail++;
      $display("FAIL short_poly: np=%0d pv=%b x0=%0d y1=%0d, want 2 0 1 4", np, pv,
               $signed(xs[0]), $signed(ys[1]));
    end
  endtask

  // Active bank holds the 2-vertex polygon (1,2)(3,4) on entry.
  task automatic test_swap_same_edge();
    cam_x = 0; cam_y = 0;
    cycle(1'b1, 20, 21, 1'b0, 1'b0);
    cycle(1'b1, 22, 23, 1'b0, 1'b0);
    cycle(1'b1, 24, 25, 1'b1, 1'b1);
    n_tests++;
    if (np !== CW'(2) || xs[0] !== WB'(1) || vif.v_ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL same_edge_hold: np=%0d x0=%0d rdy=%b, want 2 1 0", np, $signed(xs[0]),
               vif.v_ready_out);
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    n_tests++;
    if (np !== CW'(3) || pv !== 1'b1 || xs[2] !== WB'(24) || ys[0] !== WB'(21)) begin
      n_fail++;
      $display("FAIL same_edge_apply: np=%0d pv=%b x2=%0d y0=%0d, want 3 1 24 21", np, pv,
               $signed(xs[2]), $signed(ys[0]));
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      int unsigned len;
      len = $urandom_range(1, 12);
      for (int i = 0; i < int'(len); i++) begin
        while ($urandom_range(0, 3) == 0) cycle(1'b0, '0, '0, 1'b0, 1'($urandom_range(0, 1)));
        cam_x = $urandom; cam_y = $urandom;
        cycle(1'b1, $urandom, $urandom, i == int'(len) - 1, 1'($urandom_range(0, 1)));
      end
      n_tests++;
      if (vif.v_ready_out !== !m_full || np !== CW'(act_xq.size())) begin
        n_fail++;
        $display("FAIL rand%0d_pre_swap: rdy=%b np=%0d, want %b %0d", p, vif.v_ready_out, np,
                 !m_full, act_xq.size());
      end
      repeat ($urandom_range(0, 2)) cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      n_tests++;
      if (np !== CW'(act_xq.size()) || pv !== (act_xq.size() >= 3) || ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL rand%0d_swap: np=%0d pv=%b ovf=%b, want %0d %b %b", p, np, pv, ovf,
                 act_xq.size(), act_xq.size() >= 3, m_ovf);
      end
      for (int i = 0; i < act_xq.size(); i++) begin
        n_tests++;
        if (xs[i] !== act_xq[i] || ys[i] !== act_yq[i]) begin
          n_fail++;
          $display("FAIL rand%0d_entry%0d: got (%h,%h) want (%h,%h)", p, i, xs[i], ys[i],
                   act_xq[i], act_yq[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    cam_x = 0; cam_y = 0;
    for (int i = 0; i < 35; i++) cycle(1'b1, WB'(3 * i + 1), WB'(-i), i == 34, 1'b0);
    n_tests++;
    if (ovf !== 1'b1 || vif.v_ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_flag: ovf=%b rdy=%b, want 1 0", ovf, vif.v_ready_out);
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    n_tests++;
    if (np !== CW'(32) || pv !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_swap: np=%0d pv=%b ovf=%b, want 32 1 1", np, pv, ovf);
    end
    for (int i = 0; i < 32; i++) begin
      n_tests++;
      if (xs[i] !== WB'(3 * i + 1) || ys[i] !== WB'(-i)) begin
        n_fail++;
        $display("FAIL overflow_entry%0d: got (%0d,%0d) want (%0d,%0d)", i, $signed(xs[i]),
                 $signed(ys[i]), 3 * i + 1, -i);
      end
    end
  endtask

  task automatic test_reset_midload();
    cam_x = 0; cam_y = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, WB'(100 + i), WB'(200 + i), 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (np !== '0 || pv !== 1'b0 || ovf !== 1'b0 || vif.v_ready_out !== 1'b0 ||
        xs !== '0 || ys !== '0) begin
      n_fail++;
      $display("FAIL midload_reset: np=%0d pv=%b ovf=%b rdy=%b, want all 0", np, pv, ovf,
               vif.v_ready_out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (vif.v_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midload_ready: got %b want 1", vif.v_ready_out);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, WB'(50 + i), WB'(60 + i), i == 2, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    n_tests++;
    if (np !== CW'(3) || xs[0] !== WB'(50) || ys[2] !== WB'(62) || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reload: np=%0d x0=%0d y2=%0d ovf=%b, want 3 50 62 0", np,
               $signed(xs[0]), $signed(ys[2]), ovf);
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_cam_offset();
    test_short();
    test_swap_same_edge();
    test_random();
    test_overflow();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/polygon_loader.md
POLYGON_LOADER -- requirements
Module: polygon_loader

Interface
REQ-001 SHALL have parameter WORLD_BITS, default 32, signed width of every coordinate.
REQ-002 SHALL have parameter MAX_NUM_VERTICES, default 32, capacity of each vertex bank.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port vx_in, input, WORLD_BITS signed, world x of the offered vertex.
REQ-006 SHALL have port vy_in, input, WORLD_BITS signed, world y of the offered vertex.
REQ-007 SHALL have port v_valid_in, input, 1, vertex offered this cycle.
REQ-008 SHALL have port v_last_in, input, 1, offered vertex is the final vertex of its polygon.
REQ-009 SHALL have port v_ready_out, output, 1, loader accepts an offered vertex this cycle.
REQ-010 SHALL have port cam_x_in, input, WORLD_BITS signed, camera x offset.
REQ-011 SHALL have port cam_y_in, input, WORLD_BITS signed, camera y offset.
REQ-012 SHALL have port swap_in, input, 1, single-cycle frame-boundary pulse requesting a bank swap.
REQ-013 SHALL have port poly_xs_out, output, MAX_NUM_VERTICES x WORLD_BITS signed, active-bank x array.
REQ-014 SHALL have port poly_ys_out, output, MAX_NUM_VERTICES x WORLD_BITS signed, active-bank y array.
REQ-015 SHALL have port num_points_out, output, $clog2(MAX_NUM_VERTICES+1), active vertex count.
REQ-016 SHALL have port poly_valid_out, output, 1, active polygon has at least 3 vertices.
REQ-017 SHALL have port overflow_out, output, 1, sticky flag: a polygon exceeded MAX_NUM_VERTICES.

Function
REQ-018 SHALL keep two banks, shadow (being loaded) and active (driven on outputs); active outputs SHALL change only on a swap.
REQ-019 SHALL implement states LOAD and FULL; v_ready_out SHALL be 1 in LOAD and 0 in FULL, as a registered decode of state.
REQ-020 SHALL accept a vertex on any edge with v_valid_in and v_ready_out both 1; no other edge writes the shadow bank.
REQ-021 SHALL store an accepted vertex at shadow index count as (vx_in - cam_x_in, vy_in - cam_y_in), truncated to WORLD_BITS, using the cam values sampled on that same edge, then increment count.
REQ-022 SHALL, on accepting a vertex with v_last_in 1, transition LOAD -> FULL and freeze the shadow count.
REQ-023 SHALL, in LOAD with count equal to MAX_NUM_VERTICES, keep v_ready_out 1, discard further accepted vertices, saturate count, and set overflow_out; v_last_in still SHALL end the polygon.
REQ-024 SHALL, on swap_in in FULL, copy the shadow arrays and count to the active outputs on that edge (outputs visible the following cycle), reset count to 0, and return to LOAD.
REQ-025 SHALL ignore swap_in in LOAD, including the cycle in which the last vertex is accepted; the active bank is retained and the swap takes effect on the next swap_in.
REQ-026 SHALL set poly_valid_out to (copied count >= 3) on the swap edge; polygons of 0-2 vertices SHALL still be copied with num_points_out set to their count.
REQ-027 SHALL leave active entries at index >= num_points_out unspecified; consumers SHALL ignore them.
REQ-028 SHALL produce no combinational path from any input to any output.

Reset
REQ-029 SHALL, while rst_n_in is 0, force state LOAD, count 0, both banks to 0, num_points_out 0, poly_valid_out 0, and overflow_out 0; v_ready_out SHALL be 1 from the first edge after release.
REQ-030 SHALL discard any partially loaded polygon when reset asserts mid-load; overflow_out SHALL clear only on reset.

Structure
REQ-031 SHALL take WORLD_BITS, MAX_NUM_VERTICES, the vertex-count width, and the LOAD/FULL state enum from the shared package polygon_pkg.
REQ-032 SHALL be a single module with no sub-modules; the bank arrays SHALL be flip-flops, not RAM, because all entries are read in parallel.

Verification
REQ-033 SHALL test: reset, then 4 vertices (0,0) (10,0) (10,10) (0,10) with cam (0,0), last on the 4th, then swap_in -> num_points_out 4, poly_valid_out 1, arrays match, from the cycle after the swap.
REQ-034 SHALL test: cam (5,-3), single vertex (7,7) -> stored value (2,10).
REQ-035 SHALL test: 2-vertex polygon, then swap -> num_points_out 2, poly_valid_out 0.
REQ-036 SHALL test: 35 vertices with MAX_NUM_VERTICES 32 -> overflow_out 1, num_points_out 32 after swap, entries 0-31 are the first 32 vertices.
REQ-037 SHALL test: swap_in on the same edge as the last-vertex accept -> active bank unchanged, v_ready_out 0; the next swap_in applies the new polygon.
REQ-038 SHALL test: rst_n_in pulsed low mid-load after 3 vertices -> all outputs 0 immediately, v_ready_out 1 after release.
